sys_input_skew: RTL and testbench

Input staging stage directly upstream of the systolic array rows. It accepts one column vector of signed 8-bit activations per handshake, one lane per array row. It drives each row's `data_in`/`active` with a per-row diagonal skew: row r is delayed r cycles relative to row 0, so operands meet the correct partial sums as they propagate through the PEs. It also tracks tile boundaries and signals when the last vector has fully entered the array.

---
 rtl/sys_pkg.sv | 24 ++
 rtl/sys_delay_line.sv | 42 ++++
 rtl/sys_input_skew.sv | 115 +++++++++++
 tb/tb_sys_input_skew.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_pkg
// Description : Types and constants shared by the systolic-array front end.
//               It defines the input-skew FSM state type, the activation
//               width, and the PE accumulator width used downstream.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_pkg;

   // Signed activation byte width
   localparam int DATA_W = 8;

   // PE accumulator width, exported for downstream consumers
   localparam int SUM_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } skew_state_t;

endpackage : sys_pkg
`default_nettype wire

// File: rtl/sys_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sys_delay_line
// Description : A fixed-depth shift register. The input appears on the
//               output after 'depth' rising edges. All stages clear to zero
//               on reset.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               din   - stage-0 input (width bits)
//               dout  - final-stage output (width bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sys_delay_line #(
   parameter int depth = 1,
   parameter int width = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout
);

   logic [width-1:0] stage [depth];

   for (genvar i = 0; i < depth; i++) begin : g_stage
      if (i == 0) begin : g_first
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage[0] <= '0;
            else        stage[0] <= din;
         end
      end else begin : g_next
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) stage[i] <= '0;
            else        stage[i] <= stage[i-1];
         end
      end
   end

   assign dout = stage[depth-1];

endmodule : sys_delay_line
`default_nettype wire

// File: rtl/sys_input_skew.sv
`default_nettype none
// ============================================================================
// Module      : sys_input_skew
// Description : Input staging for the systolic array rows. It accepts one
//               column vector of signed 8-bit activations per handshake and
//               feeds row r delayed by r cycles relative to row 0. It tracks
//               tile boundaries and pulses 'done' once the last vector of a
//               tile has fully entered the array.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               in_valid   - upstream vector valid
//               in_ready   - vector can be accepted this cycle
//               in_data    - packed activations, lane 0 in the LSBs
//               in_last    - accepted vector is the last of its tile
//               row_data   - per-row data_in to the array, same packing
//               row_active - per-row active qualifier
//               busy       - high whenever the FSM is not idle
//               done       - one-cycle pulse, tile fully injected
// Revision    : 1.0 - initial release
// ============================================================================
module sys_input_skew
   import sys_pkg::*;
#(
   parameter int num_rows = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W*num_rows-1:0] in_data,
   input  logic                       in_last,
   output logic [DATA_W*num_rows-1:0] row_data,
   output logic [num_rows-1:0]        row_active,
   output logic                       busy,
   output logic                       done
);

   localparam int cnt_width = $clog2(num_rows + 1);
   localparam logic [cnt_width-1:0] drain_load = cnt_width'(num_rows - 1);

   skew_state_t          state;
   logic [cnt_width-1:0] cnt;
   logic                 accept;

   // Ready depends only on state so upstream can never form a comb loop
   assign in_ready = (state != DRAIN);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   // DRAIN holds off new vectors until the last one reaches the bottom row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (in_last) begin
                     state <= DRAIN;
                     cnt   <= drain_load;
                  end else begin
                     state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (accept && in_last) begin
                  state <= DRAIN;
                  cnt   <= drain_load;
               end
            end
            DRAIN: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Lane r uses r+1 stages. Non-accepted cycles inject a zero bubble so
   // the data byte is never nonzero while its active bit is low.
   for (genvar r = 0; r < num_rows; r++) begin : g_lane
      logic [DATA_W:0] lane_in;
      logic [DATA_W:0] lane_out;

      assign lane_in = {accept,
                        accept ? in_data[DATA_W*r +: DATA_W] : {DATA_W{1'b0}}};

      sys_delay_line #(
         .depth (r + 1),
         .width (DATA_W + 1)
      ) u_delay (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (lane_in),
         .dout  (lane_out)
      );

      assign row_active[r]                 = lane_out[DATA_W];
      assign row_data[DATA_W*r +: DATA_W]  = lane_out[DATA_W-1:0];
   end

endmodule : sys_input_skew
`default_nettype wire

// File: tb/tb_sys_input_skew.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_input_skew
// Description : Self-checking bench for sys_input_skew. It drives a 4-row
//               and a 1-row instance. The outputs are compared against a
//               history-based reference model, and there are directed
//               sequences for the tile corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_input_skew;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        iv   [2];
   logic        il   [2];
   logic [31:0] idat [2];

   logic        rdy4, busy4, done4;
   logic [31:0] rd4;
   logic [3:0]  ra4;
   logic        rdy1, busy1, done1;
   logic [7:0]  rd1;
   logic [0:0]  ra1;

   sys_input_skew #(.num_rows(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy4),
      .in_data(idat[0]), .in_last(il[0]), .row_data(rd4),
      .row_active(ra4), .busy(busy4), .done(done4)
   );

   sys_input_skew #(.num_rows(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy1),
      .in_data(idat[1][7:0]), .in_last(il[1]), .row_data(rd1),
      .row_active(ra1), .busy(busy1), .done(done1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[d][k] is what was presented to the array k edges ago.
   typedef struct packed {
      logic        act;
      logic [31:0] data;
   } ent_t;

   ent_t hist       [2][4];
   int   drain_left [2];
   bit   in_tile    [2];
   bit   done_m     [2];
   int   nrows      [2];

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         drain_left[d] = 0;
         in_tile[d]    = 1'b0;
         done_m[d]     = 1'b0;
         for (int k = 0; k < 4; k++) hist[d][k] = '0;
      end
   endtask

   function automatic bit ready_m(input int d);
      return drain_left[d] == 0;
   endfunction

   task automatic model_edge(input int d);
      bit          acc;
      logic [31:0] mask;
      acc  = iv[d] && (drain_left[d] == 0);
      mask = (nrows[d] == 4) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
      hist[d][0].act  = acc;
      hist[d][0].data = acc ? (idat[d] & mask) : 32'h0;
      done_m[d] = 1'b0;
      if (drain_left[d] > 0) begin
         drain_left[d]--;
         if (drain_left[d] == 0) done_m[d] = 1'b1;
      end else if (acc) begin
         if (il[d]) begin
            drain_left[d] = nrows[d];
            in_tile[d]    = 1'b0;
         end else begin
            in_tile[d] = 1'b1;
         end
      end
   endtask

   task automatic check_model();
      logic [31:0] ed;
      logic [3:0]  ea;
      for (int d = 0; d < 2; d++) begin
         ed = '0;
         ea = '0;
         for (int r = 0; r < nrows[d]; r++) begin
            ed[8*r +: 8] = hist[d][r].data[8*r +: 8];
            ea[r]        = hist[d][r].act;
         end
         if (d == 0) begin
            chk("m4_row_data",   rd4,          ed);
            chk("m4_row_active", {28'h0, ra4}, {28'h0, ea});
            chk("m4_busy",  {31'h0, busy4}, {31'h0, in_tile[0] || drain_left[0] > 0});
            chk("m4_done",  {31'h0, done4}, {31'h0, done_m[0]});
            chk("m4_ready", {31'h0, rdy4},  {31'h0, ready_m(0)});
         end else begin
            chk("m1_row_data",   {24'h0, rd1}, {24'h0, ed[7:0]});
            chk("m1_row_active", {31'h0, ra1}, {31'h0, ea[0]});
            chk("m1_busy",  {31'h0, busy1}, {31'h0, in_tile[1] || drain_left[1] > 0});
            chk("m1_done",  {31'h0, done1}, {31'h0, done_m[1]});
            chk("m1_ready", {31'h0, rdy1},  {31'h0, ready_m(1)});
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         model_edge(0);
         model_edge(1);
      end
      #1;
      check_model();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        v;
      logic        l;
      logic [31:0] d;
      logic [31:0] e_data;
      logic [3:0]  e_act;
      logic        e_busy;
      logic        e_done;
      logic        e_ready;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [31:0] seq_in  [4];
      logic [31:0] obs_d   [9];
      logic [3:0]  obs_a   [9];
      logic [7:0]  v1      [5];
      int          tile_pos;
      bit          prev_done;
      bit          rdy_before;

      nrows[0] = 4;
      nrows[1] = 1;

      tbl[0] = '{1'b1, 1'b1, 32'h0403_0201, 32'h0000_0001, 4'b0001, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0200, 4'b0010, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0003_0000, 4'b0100, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0400_0000, 4'b1000, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b1};

      // Reset held with valid high: nothing may be accepted
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b1; il[d] = 1'b0; idat[d] = 32'h1122_3344;
      end
      model_clear();
      #1;
      check_model();
      step();
      step();
      for (int d = 0; d < 2; d++) iv[d] = 1'b0;
      rst_n = 1'b1;
      step();

      // Single-vector tile on 4 rows
      for (int i = 0; i < 6; i++) begin
         iv[0] = tbl[i].v; il[0] = tbl[i].l; idat[0] = tbl[i].d;
         step();
         chk("tbl_row_data",   rd4,            tbl[i].e_data);
         chk("tbl_row_active", {28'h0, ra4},   {28'h0, tbl[i].e_act});
         chk("tbl_busy",       {31'h0, busy4}, {31'h0, tbl[i].e_busy});
         chk("tbl_done",       {31'h0, done4}, {31'h0, tbl[i].e_done});
         chk("tbl_ready",      {31'h0, rdy4},  {31'h0, tbl[i].e_ready});
      end

      // A, B, bubble, C(last) with negative bytes
      seq_in[0] = 32'h8010_2081;
      seq_in[1] = 32'h7F90_A080;
      seq_in[2] = 32'h0000_0000;
      seq_in[3] = 32'hFE33_4480;
      for (int t = 0; t < 9; t++) begin
         iv[0]   = (t < 4) && (t != 2);
         il[0]   = (t == 3);
         idat[0] = (t < 4) ? seq_in[t] : 32'h5555_5555;
         step();
         obs_d[t] = rd4;
         obs_a[t] = ra4;
      end
      for (int k = 0; k < 4; k++) begin
         chk("seq_row0_data", {24'h0, obs_d[k][7:0]},   {24'h0, seq_in[k][7:0]});
         chk("seq_row0_act",  {31'h0, obs_a[k][0]},     {31'h0, k != 2});
         chk("seq_row3_data", {24'h0, obs_d[k+3][31:24]}, {24'h0, seq_in[k][31:24]});
         chk("seq_row3_act",  {31'h0, obs_a[k+3][3]},   {31'h0, k != 2});
      end

      // Tile chaining: valid held high, two-vector tiles
      tile_pos  = 0;
      prev_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         iv[0]   = 1'b1;
         il[0]   = (tile_pos == 1);
         idat[0] = $urandom;
         rdy_before = ready_m(0);
         step();
         if (rdy_before) tile_pos ^= 1;
         if (prev_done) chk("chain_accept_after_done", {31'h0, ra4[0]}, 32'h1);
         prev_done = done4;
      end
      iv[0] = 1'b0;
      repeat (6) step();

      // Reset one cycle after the last accept
      iv[0] = 1'b1; il[0] = 1'b1; idat[0] = 32'hA5A5_A5A5;
      step();
      iv[0] = 1'b0;
      step();
      rst_n = 1'b0;
      model_clear();
      #1;
      check_model();
      chk("rst_mid_busy",     {31'h0, busy4}, 32'h0);
      chk("rst_mid_row_data", rd4,            32'h0);
      step();
      chk("rst_mid_no_done",  {31'h0, done4}, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Single-row instance: five-vector tile
      v1[0] = 8'h80; v1[1] = 8'h7F; v1[2] = 8'h01; v1[3] = 8'hFF; v1[4] = 8'h3C;
      for (int k = 0; k < 5; k++) begin
         iv[1] = 1'b1; il[1] = (k == 4); idat[1] = {24'hABCDEF, v1[k]};
         step();
         chk("n1_row_data", {24'h0, rd1}, {24'h0, v1[k]});
         chk("n1_row_act",  {31'h0, ra1}, 32'h1);
      end
      iv[1] = 1'b0;
      step();
      chk("n1_done",       {31'h0, done1}, 32'h1);
      chk("n1_row_act_off", {31'h0, ra1},  32'h0);
      step();
      chk("n1_done_once",  {31'h0, done1}, 32'h0);

      // Random traffic on both instances
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 2; d++) begin
            iv[d]   = ($urandom_range(0, 3) != 0);
            il[d]   = ($urandom_range(0, 4) == 0);
            idat[d] = $urandom;
         end
         step();
      end
      for (int d = 0; d < 2; d++) iv[d] = 1'b0;
      repeat (6) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sys_input_skew
`default_nettype wire
